ad1939_adc_rx: RTL

Serial receiver for the AD1939 codec ADC path, sitting directly upstream of the HPS/Avalon fabric in the audio passthrough system.
- Oversamples the codec's ABCLK, ALRCLK and ASDATA in the system clock domain.
- Deserialises I2S-format 2-channel frames.
- Presents each 24-bit sample as an Avalon-ST beat with a channel tag to the downstream processing/FIR stage.
- Reports overrun and framing errors as sticky flags.

---
 rtl/ad1939_adc_rx.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ad1939_adc_rx.sv
`default_nettype none
// ============================================================================
// Module      : ad1939_adc_rx
// Description : AD1939 ADC-path I2S receiver. Oversamples ABCLK, ALRCLK and
//               ASDATA in the system clock domain. Deserialises 2-channel I2S
//               frames. Presents each sample as an Avalon-ST beat with a
//               channel tag, and raises sticky overrun / framing flags.
// Ports       :
//   clk               system clock, at least 4x ABCLK
//   reset_n           asynchronous active-low reset
//   ad1939_abclk      codec bit clock (asynchronous to clk)
//   ad1939_alrclk     codec frame clock, 0 = left, 1 = right
//   ad1939_asdata     codec ADC serial data, MSB first
//   avalon_st_data    sample, two's complement
//   avalon_st_channel 0 = left, 1 = right
//   avalon_st_valid   sample valid
//   avalon_st_ready   downstream accept
//   overrun           sticky: a sample was dropped
//   framing_error     sticky: a slot had the wrong length
//   err_clr           synchronous clear of both sticky flags
// Revision    : 1.0 - initial release
// ============================================================================
module ad1939_adc_rx #(
    parameter int DATA_WIDTH  = 24,
    parameter int SLOT_BITS   = 32,
    parameter int SYNC_STAGES = 2     // must be 2 or more
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ad1939_abclk,
    input  logic                  ad1939_alrclk,
    input  logic                  ad1939_asdata,
    output logic [DATA_WIDTH-1:0] avalon_st_data,
    output logic                  avalon_st_channel,
    output logic                  avalon_st_valid,
    input  logic                  avalon_st_ready,
    output logic                  overrun,
    output logic                  framing_error,
    input  logic                  err_clr
);

    // Bit counter is 6 bits wide and saturates, so a stuck LRCLK can never
    // wrap it back round to a value that looks like a legal slot length.
    localparam logic [5:0] c_CNT_MAX  = 6'd63;
    localparam logic [5:0] c_SLOT_LEN = 6'(SLOT_BITS);
    localparam logic [5:0] c_LSB_IDX  = 6'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAD   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronisers: identical depth on all three codec pins so that
    // data, frame and bit clock keep their pin-level phase relationship.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrclk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_sync  <= '0;
            r_lrclk_sync <= '0;
            r_data_sync  <= '0;
        end else begin
            r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0],  ad1939_abclk};
            r_lrclk_sync <= {r_lrclk_sync[SYNC_STAGES-2:0], ad1939_alrclk};
            r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0],  ad1939_asdata};
        end
    end

    logic w_bclk;
    logic w_lrclk;
    logic w_data;

    assign w_bclk  = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrclk = r_lrclk_sync[SYNC_STAGES-1];
    assign w_data  = r_data_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Bit-clock edge and frame-edge detection
    // ------------------------------------------------------------------------
    logic r_bclk_d;
    logic r_lr_prev;   // ALRCLK as seen at the previous bclk rise
    logic r_lr_seen;   // r_lr_prev holds a real sample (not the reset value)
    logic w_bclk_rise;
    logic w_lr_edge;

    assign w_bclk_rise = w_bclk & ~r_bclk_d;
    // Without r_lr_seen, coming out of reset in a right slot would compare
    // against the reset value 0 and fake a frame edge mid-word.
    assign w_lr_edge   = w_bclk_rise & r_lr_seen & (w_lrclk != r_lr_prev);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_d  <= 1'b0;
            r_lr_prev <= 1'b0;
            r_lr_seen <= 1'b0;
        end else begin
            r_bclk_d <= w_bclk;
            if (w_bclk_rise) begin
                r_lr_prev <= w_lrclk;
                r_lr_seen <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Deserialiser FSM
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [5:0]            r_bit_cnt;
    logic                  r_ch;
    logic [DATA_WIDTH-1:0] r_shift;

    state_t                w_next_state;
    logic [5:0]            w_next_cnt;
    logic                  w_next_ch;
    logic [DATA_WIDTH-1:0] w_next_shift;
    logic [5:0]            w_cnt_inc;
    logic                  w_emit;
    logic                  w_frame_bad;

    assign w_cnt_inc = (r_bit_cnt == c_CNT_MAX) ? c_CNT_MAX : r_bit_cnt + 6'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_HUNT;
            r_bit_cnt <= '0;
            r_ch      <= 1'b0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_bit_cnt <= w_next_cnt;
            r_ch      <= w_next_ch;
            r_shift   <= w_next_shift;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_bit_cnt;
        w_next_ch    = r_ch;
        w_next_shift = r_shift;
        w_emit       = 1'b0;
        w_frame_bad  = 1'b0;

        if (w_bclk_rise) begin
            if (w_lr_edge) begin
                // A frame edge restarts the slot from any state. The bit
                // sampled on the edge itself is the I2S one-bit delay slot
                // and is not shifted. A short word still in ST_SHIFT is
                // simply abandoned here.
                if ((r_state != ST_HUNT) && (r_bit_cnt != c_SLOT_LEN)) begin
                    w_frame_bad = 1'b1;
                end
                w_next_ch    = w_lrclk;
                w_next_cnt   = 6'd1;
                w_next_state = ST_SHIFT;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        w_next_state = ST_HUNT;
                    end
                    ST_SHIFT: begin
                        w_next_shift = {r_shift[DATA_WIDTH-2:0], w_data};
                        w_next_cnt   = w_cnt_inc;
                        if (r_bit_cnt == c_LSB_IDX) begin
                            w_emit       = 1'b1;
                            w_next_state = ST_PAD;
                        end
                    end
                    ST_PAD: begin
                        w_next_cnt = w_cnt_inc;
                    end
                    default: begin
                        w_next_state = ST_HUNT;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register and sticky error flags
    // ------------------------------------------------------------------------
    // The emit is registered once so that r_shift and r_ch have settled to
    // the completed word before the output register samples them. The next
    // bclk rise is at least 4 clk cycles away, so they are stable here.
    logic                  r_emit;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_out_ch;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  r_framing;
    logic                  w_overrun_set;

    assign w_overrun_set = r_emit & r_valid & ~avalon_st_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_emit    <= 1'b0;
            r_data    <= '0;
            r_out_ch  <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_framing <= 1'b0;
        end else begin
            r_emit <= w_emit;

            if (r_emit) begin
                // A new word either replaces a beat being accepted this
                // cycle, fills an empty register, or is dropped.
                if (!w_overrun_set) begin
                    r_data   <= r_shift;
                    r_out_ch <= r_ch;
                    r_valid  <= 1'b1;
                end
            end else if (r_valid && avalon_st_ready) begin
                r_valid <= 1'b0;
            end

            // A set event in the same cycle as err_clr keeps the flag high.
            r_overrun <= w_overrun_set | (r_overrun & ~err_clr);
            r_framing <= w_frame_bad   | (r_framing & ~err_clr);
        end
    end

    assign avalon_st_data    = r_data;
    assign avalon_st_channel = r_out_ch;
    assign avalon_st_valid   = r_valid;
    assign overrun           = r_overrun;
    assign framing_error     = r_framing;

endmodule
`default_nettype wire
